// File: rtl/reg_file.sv
// Register file: 2^ADDR_W x WIDTH, one write port, two registered read ports, R0 hardwired to zero.
// Define RF_BYPASS_EN to forward same-edge write data to a colliding read (write-first).
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             wr_ok;

    assign wr_ok = we && (waddr != '0);

    always_comb begin
        rd_a = mem[raddr_a];
        rd_b = mem[raddr_b];
`ifdef RF_BYPASS_EN
        if (wr_ok && (waddr == raddr_a)) rd_a = wdata;
        if (wr_ok && (waddr == raddr_b)) rd_b = wdata;
`endif
        // R0 reads zero even if a write to it is in flight
        if (raddr_a == '0) rd_a = '0;
        if (raddr_b == '0) rd_b = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else if (re) begin
            rdata_a <= rd_a;
            rdata_b <= rd_b;
        end
    end

endmodule
